// File: rtl/word_fetch_scheduler.sv
// Round-robin scheduler sharing the qspi word-list fetch path between two requesters.
// Optional one-entry result cache is enabled by defining WORD_FETCH_CACHE_EN.
module word_fetch_scheduler #(
    parameter int FETCH_CYCLES = 40,
    parameter int GUARD_CYCLES = 48
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        offscreen,
    input  logic [11:0] window_left,
    input  logic        req0,
    input  logic        req1,
    input  logic [23:0] addr0,
    input  logic [23:0] addr1,
    output logic        gnt0,
    output logic        gnt1,
    output logic        done0,
    output logic        done1,
    output logic [31:0] rdata,
    output logic        fetch,
    output logic [23:0] fetch_addr,
    input  logic [31:0] fetch_result,
    output logic        busy,
    output logic [7:0]  abort_count
);
    localparam int CNT_W = $clog2(FETCH_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(FETCH_CYCLES);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(1);
    localparam logic [11:0] GUARD = 12'(GUARD_CYCLES);

    typedef enum logic [1:0] {IDLE, WAIT, DONE} state_t;

    state_t           state;
    logic [CNT_W-1:0] cnt;
    logic             last_served;
    logic             cur;

    logic             any_req;
    logic             sel;
    logic [23:0]      sel_addr;
    logic             window_ok;
    logic             fetch_done;
    logic             cache_hit;
    logic [31:0]      hit_data;

    function automatic logic [7:0] sat_inc(input logic [7:0] v);
        return (v == 8'hff) ? v : v + 8'd1;
    endfunction

    // With both requesting, the one not served last wins; an aborted fetch leaves
    // last_served untouched so the same requester is retried first.
    assign any_req    = req0 | req1;
    assign sel        = (req0 && req1) ? ~last_served : req1;
    assign sel_addr   = sel ? addr1 : addr0;
    assign window_ok  = offscreen && (window_left >= GUARD);
    assign fetch_done = (state == WAIT) && offscreen && (cnt == CNT_LAST);

`ifdef WORD_FETCH_CACHE_EN
    logic        cache_valid;
    logic [23:0] cache_tag;
    logic [31:0] cache_data;

    always_ff @(posedge clk) begin
        if (rst)
            cache_valid <= 1'b0;
        else if (fetch_done)
            cache_valid <= 1'b1;
    end

    always_ff @(posedge clk) begin
        if (fetch_done) begin
            cache_tag  <= fetch_addr;
            cache_data <= fetch_result;
        end
    end

    assign cache_hit = cache_valid && (sel_addr == cache_tag);
    assign hit_data  = cache_data;
`else
    assign cache_hit = 1'b0;
    assign hit_data  = '0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            busy        <= 1'b0;
            cnt         <= '0;
            cur         <= 1'b0;
            last_served <= 1'b1;
            gnt0        <= 1'b0;
            gnt1        <= 1'b0;
            done0       <= 1'b0;
            done1       <= 1'b0;
            fetch       <= 1'b0;
            fetch_addr  <= '0;
            rdata       <= '0;
            abort_count <= '0;
        end else begin
            gnt0  <= 1'b0;
            gnt1  <= 1'b0;
            done0 <= 1'b0;
            done1 <= 1'b0;
            fetch <= 1'b0;
            case (state)
                IDLE: begin
                    if (any_req && cache_hit) begin
                        gnt0        <= ~sel;
                        gnt1        <= sel;
                        done0       <= ~sel;
                        done1       <= sel;
                        rdata       <= hit_data;
                        last_served <= sel;
                        state       <= DONE;
                        busy        <= 1'b1;
                    end else if (any_req && window_ok) begin
                        fetch      <= 1'b1;
                        fetch_addr <= sel_addr;
                        gnt0       <= ~sel;
                        gnt1       <= sel;
                        cur        <= sel;
                        cnt        <= CNT_LOAD;
                        state      <= WAIT;
                        busy       <= 1'b1;
                    end
                end
                WAIT: begin
                    // A closing window wins over completion in the same cycle.
                    if (!offscreen) begin
                        state       <= IDLE;
                        busy        <= 1'b0;
                        abort_count <= sat_inc(abort_count);
                    end else if (fetch_done) begin
                        rdata       <= fetch_result;
                        done0       <= ~cur;
                        done1       <= cur;
                        last_served <= cur;
                        state       <= DONE;
                    end else begin
                        cnt <= cnt - CNT_LAST;
                    end
                end
                DONE: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_word_fetch_scheduler.sv
// Self-checking bench for word_fetch_scheduler with a behavioural flash and arbitration model.
module tb_word_fetch_scheduler;
    localparam int FC = 40;
    localparam int GC = 48;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        offscreen = 1'b0;
    logic [11:0] window_left = '0;
    logic        req0 = 1'b0, req1 = 1'b0;
    logic [23:0] addr0 = '0, addr1 = '0;
    logic        gnt0, gnt1, done0, done1, fetch, busy;
    logic [31:0] rdata;
    logic [23:0] fetch_addr;
    logic [31:0] fetch_result = '0;
    logic [7:0]  abort_count;

    int total = 0;
    int bad = 0;
    int cyc = 0;
    int fetch_n = 0;
    int abort_exp = 0;
    int seq = 16;
    int fl_age = 1000;
    logic [23:0] fl_addr = '0;
    logic [31:0] salt;

    always #5 clk = ~clk;

    word_fetch_scheduler #(.FETCH_CYCLES(FC), .GUARD_CYCLES(GC)) dut (
        .clk(clk), .rst(rst), .offscreen(offscreen), .window_left(window_left),
        .req0(req0), .req1(req1), .addr0(addr0), .addr1(addr1),
        .gnt0(gnt0), .gnt1(gnt1), .done0(done0), .done1(done1), .rdata(rdata),
        .fetch(fetch), .fetch_addr(fetch_addr), .fetch_result(fetch_result),
        .busy(busy), .abort_count(abort_count)
    );

    // Flash content: a fixed scramble of the address.
    function automatic logic [31:0] flash_word(input logic [23:0] a);
        return {a[11:0], a[23:4]} ^ salt;
    endfunction

    task automatic fresh_addr(output logic [23:0] a);
        seq++;
        a = {seq[11:0], 12'($urandom)};
    endtask

    // One clock: outputs are inspected 1 time unit after the edge. The qspi model
    // presents the word only from FC-1 cycles after the fetch pulse onward.
    task automatic step();
        @(posedge clk);
        #1;
        cyc++;
        if (fetch) begin
            fl_addr = fetch_addr;
            fl_age  = 0;
            fetch_n++;
        end else if (fl_age < 1000) begin
            fl_age++;
        end
        fetch_result = (fl_age >= FC - 1) ? flash_word(fl_addr) : ~flash_word(fl_addr);
    endtask

    task automatic wait_done(input int budget, output int n, output bit ok);
        n = 0;
        ok = 1'b0;
        while (n < budget) begin
            step();
            n++;
            if (done0 || done1) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        step();
        step();
        total++;
        if ({gnt0, gnt1, done0, done1, fetch, busy} !== 6'b0) begin
            bad++;
            $display("FAIL reset_pulses got=%b want=000000", {gnt0, gnt1, done0, done1, fetch, busy});
        end
        total++;
        if (rdata !== 32'h0) begin bad++; $display("FAIL reset_rdata got=%h want=0", rdata); end
        total++;
        if (fetch_addr !== 24'h0) begin bad++; $display("FAIL reset_fetch_addr got=%h want=0", fetch_addr); end
        total++;
        if (abort_count !== 8'h0) begin bad++; $display("FAIL reset_abort_count got=%0d want=0", abort_count); end
        rst = 1'b0;
    endtask

    task automatic test_single_fetch();
        logic [23:0] a;
        int n;
        bit ok, who;
        offscreen = 1'b1;
        window_left = 12'd500;
        for (int i = 0; i < 4; i++) begin
            who = i[0];
            if (i == 0) a = 24'h001234; else fresh_addr(a);
            if (who) begin addr1 = a; req1 = 1'b1; end
            else begin addr0 = a; req0 = 1'b1; end
            step();
            total++;
            if (fetch !== 1'b1 || fetch_addr !== a || gnt0 !== !who || gnt1 !== who || busy !== 1'b1) begin
                bad++;
                $display("FAIL single_issue got fetch=%b addr=%h gnt=%b%b busy=%b want fetch=1 addr=%h gnt=%b%b busy=1",
                         fetch, fetch_addr, gnt1, gnt0, busy, a, who, !who);
            end
            wait_done(FC + 5, n, ok);
            total++;
            if (!ok || n != FC) begin bad++; $display("FAIL single_latency got=%0d want=%0d", ok ? n : -1, FC); end
            total++;
            if (done0 !== !who || done1 !== who || rdata !== flash_word(a)) begin
                bad++;
                $display("FAIL single_done got done=%b%b rdata=%h want done=%b%b rdata=%h",
                         done1, done0, rdata, who, !who, flash_word(a));
            end
            req0 = 1'b0;
            req1 = 1'b0;
            step();
            total++;
            if (busy !== 1'b0 || done0 !== 1'b0 || done1 !== 1'b0 || rdata !== flash_word(a)) begin
                bad++;
                $display("FAIL single_after got busy=%b done=%b%b rdata=%h want busy=0 done=00 rdata=%h",
                         busy, done1, done0, rdata, flash_word(a));
            end
        end
    endtask

    task automatic test_round_robin();
        logic [23:0] a0, a1;
        int n, f0;
        bit ok, ls, w;
        rst = 1'b1;
        step();
        rst = 1'b0;
        offscreen = 1'b1;
        window_left = 12'd500;
        step();
        ls = 1'b1;
        f0 = 0;
        for (int r = 0; r < 2; r++) begin
            fresh_addr(a0);
            fresh_addr(a1);
            addr0 = a0; addr1 = a1;
            req0 = 1'b1; req1 = 1'b1;
            for (int k = 0; k < 2; k++) begin
                if (req0 && req1) w = ~ls; else w = req1;
                step();
                if (k == 1) step();
                total++;
                if (fetch !== 1'b1 || gnt0 !== !w || gnt1 !== w || fetch_addr !== (w ? a1 : a0)) begin
                    bad++;
                    $display("FAIL rr_grant round=%0d k=%0d got fetch=%b gnt=%b%b addr=%h want fetch=1 gnt=%b%b addr=%h",
                             r, k, fetch, gnt1, gnt0, fetch_addr, w, !w, w ? a1 : a0);
                end
                if (k == 1) begin
                    total++;
                    if (cyc - f0 != FC + 2) begin bad++; $display("FAIL rr_spacing got=%0d want=%0d", cyc - f0, FC + 2); end
                end
                f0 = cyc;
                wait_done(FC + 5, n, ok);
                total++;
                if (!ok || done0 !== !w || done1 !== w || rdata !== flash_word(w ? a1 : a0)) begin
                    bad++;
                    $display("FAIL rr_done got done=%b%b rdata=%h want done=%b%b rdata=%h",
                             done1, done0, rdata, w, !w, flash_word(w ? a1 : a0));
                end
                ls = w;
                if (w) req1 = 1'b0; else req0 = 1'b0;
            end
            step();
        end
    endtask

    task automatic test_window_guard();
        logic [23:0] a;
        int nf, n;
        bit ok;
        offscreen = 1'b1;
        for (int i = 0; i < 3; i++) begin
            fresh_addr(a);
            addr0 = a;
            window_left = (i == 0) ? 12'd47 : 12'($urandom_range(0, GC - 1));
            req0 = 1'b1;
            nf = fetch_n;
            repeat (6) step();
            offscreen = 1'b0;
            window_left = 12'd4000;
            repeat (4) step();
            total++;
            if (fetch_n != nf || busy !== 1'b0) begin
                bad++;
                $display("FAIL guard_blocked got fetches=%0d busy=%b want fetches=0 busy=0", fetch_n - nf, busy);
            end
            offscreen = 1'b1;
            window_left = (i == 0) ? 12'd48 : 12'($urandom_range(GC, 4095));
            step();
            total++;
            if (fetch !== 1'b1 || fetch_addr !== a || gnt0 !== 1'b1) begin
                bad++;
                $display("FAIL guard_issue got fetch=%b addr=%h gnt0=%b want fetch=1 addr=%h gnt0=1", fetch, fetch_addr, gnt0, a);
            end
            wait_done(FC + 5, n, ok);
            total++;
            if (!ok || n != FC || rdata !== flash_word(a)) begin
                bad++;
                $display("FAIL guard_done got lat=%0d rdata=%h want lat=%0d rdata=%h", ok ? n : -1, rdata, FC, flash_word(a));
            end
            req0 = 1'b0;
            step();
        end
    endtask

    task automatic test_abort();
        logic [23:0] a;
        int d, hold, nf, n;
        bit ok;
        rst = 1'b1;
        step();
        rst = 1'b0;
        offscreen = 1'b1;
        window_left = 12'd500;
        abort_exp = 0;
        for (int i = 0; i < 4; i++) begin
            fresh_addr(a);
            addr1 = a;
            req1 = 1'b1;
            d = (i == 0) ? 9 : $urandom_range(0, FC - 2);
            step();
            total++;
            if (fetch !== 1'b1 || gnt1 !== 1'b1 || fetch_addr !== a) begin
                bad++;
                $display("FAIL abort_issue got fetch=%b gnt1=%b addr=%h want 1 1 %h", fetch, gnt1, fetch_addr, a);
            end
            repeat (d) step();
            offscreen = 1'b0;
            step();
            abort_exp++;
            total++;
            if (busy !== 1'b0 || done1 !== 1'b0 || abort_count !== 8'(abort_exp)) begin
                bad++;
                $display("FAIL abort_state d=%0d got busy=%b done1=%b aborts=%0d want busy=0 done1=0 aborts=%0d",
                         d, busy, done1, abort_count, abort_exp);
            end
            hold = $urandom_range(0, 4);
            nf = fetch_n;
            repeat (hold) step();
            offscreen = 1'b1;
            step();
            total++;
            if (fetch_n != nf + 1 || fetch !== 1'b1 || gnt1 !== 1'b1 || fetch_addr !== a) begin
                bad++;
                $display("FAIL abort_retry got fetches=%0d fetch=%b gnt1=%b addr=%h want fetches=1 fetch=1 gnt1=1 addr=%h",
                         fetch_n - nf, fetch, gnt1, fetch_addr, a);
            end
            wait_done(FC + 5, n, ok);
            total++;
            if (!ok || n != FC || done1 !== 1'b1 || rdata !== flash_word(a) || abort_count !== 8'(abort_exp)) begin
                bad++;
                $display("FAIL abort_complete got lat=%0d rdata=%h aborts=%0d want lat=%0d rdata=%h aborts=%0d",
                         ok ? n : -1, rdata, abort_count, FC, flash_word(a), abort_exp);
            end
            req1 = 1'b0;
            step();
        end
    endtask

    task automatic test_abort_saturation();
        logic [23:0] a;
        int nf, ea;
        fresh_addr(a);
        addr0 = a;
        req0 = 1'b1;
        window_left = 12'd500;
        nf = fetch_n;
        for (int i = 0; i < 260; i++) begin
            offscreen = 1'b1;
            step();
            offscreen = 1'b0;
            step();
            abort_exp++;
            ea = (abort_exp > 255) ? 255 : abort_exp;
            total++;
            if (abort_count !== 8'(ea)) begin
                bad++;
                $display("FAIL sat_count i=%0d got=%0d want=%0d", i, abort_count, ea);
            end
        end
        total++;
        if (fetch_n - nf != 260) begin bad++; $display("FAIL sat_fetches got=%0d want=260", fetch_n - nf); end
        req0 = 1'b0;
        offscreen = 1'b1;
        step();
    endtask

    task automatic test_reset_mid();
        logic [23:0] a;
        int n;
        bit ok;
        fresh_addr(a);
        addr1 = a;
        req1 = 1'b1;
        offscreen = 1'b1;
        window_left = 12'd500;
        step();
        repeat (19) step();
        rst = 1'b1;
        step();
        total++;
        if ({gnt0, gnt1, done0, done1, fetch, busy} !== 6'b0 || rdata !== 32'h0 ||
            fetch_addr !== 24'h0 || abort_count !== 8'h0) begin
            bad++;
            $display("FAIL midreset_values got pulses=%b rdata=%h addr=%h aborts=%0d want all zero",
                     {gnt0, gnt1, done0, done1, fetch, busy}, rdata, fetch_addr, abort_count);
        end
        rst = 1'b0;
        step();
        total++;
        if (fetch !== 1'b1 || gnt1 !== 1'b1 || fetch_addr !== a) begin
            bad++;
            $display("FAIL midreset_refetch got fetch=%b gnt1=%b addr=%h want 1 1 %h", fetch, gnt1, fetch_addr, a);
        end
        wait_done(FC + 5, n, ok);
        total++;
        if (!ok || n != FC || done1 !== 1'b1 || rdata !== flash_word(a)) begin
            bad++;
            $display("FAIL midreset_done got lat=%0d rdata=%h want lat=%0d rdata=%h", ok ? n : -1, rdata, FC, flash_word(a));
        end
        req1 = 1'b0;
        step();
    endtask

    task automatic test_cache();
        int n, nf;
        bit ok;
        addr0 = 24'h000400;
        req0 = 1'b1;
        offscreen = 1'b1;
        window_left = 12'd500;
        step();
        wait_done(FC + 5, n, ok);
        total++;
        if (!ok || rdata !== flash_word(24'h000400)) begin
            bad++;
            $display("FAIL cache_first got rdata=%h want=%h", rdata, flash_word(24'h000400));
        end
        req0 = 1'b0;
        step();
        offscreen = 1'b0;
        addr1 = 24'h000400;
        req1 = 1'b1;
        nf = fetch_n;
`ifdef WORD_FETCH_CACHE_EN
        step();
        total++;
        if (gnt1 !== 1'b1 || done1 !== 1'b1 || fetch !== 1'b0 || busy !== 1'b1 ||
            fetch_n != nf || rdata !== flash_word(24'h000400)) begin
            bad++;
            $display("FAIL cache_hit got gnt1=%b done1=%b fetch=%b busy=%b rdata=%h want 1 1 0 1 %h",
                     gnt1, done1, fetch, busy, rdata, flash_word(24'h000400));
        end
        req1 = 1'b0;
        step();
        total++;
        if (busy !== 1'b0) begin bad++; $display("FAIL cache_after got busy=%b want=0", busy); end
`else
        repeat (6) step();
        total++;
        if (fetch_n != nf || done1 !== 1'b0 || busy !== 1'b0) begin
            bad++;
            $display("FAIL nocache_blocked got fetches=%0d done1=%b busy=%b want 0 0 0", fetch_n - nf, done1, busy);
        end
        offscreen = 1'b1;
        step();
        total++;
        if (fetch !== 1'b1 || gnt1 !== 1'b1 || fetch_addr !== 24'h000400) begin
            bad++;
            $display("FAIL nocache_fetch got fetch=%b gnt1=%b addr=%h want 1 1 000400", fetch, gnt1, fetch_addr);
        end
        wait_done(FC + 5, n, ok);
        total++;
        if (!ok || n != FC || done1 !== 1'b1 || rdata !== flash_word(24'h000400)) begin
            bad++;
            $display("FAIL nocache_done got lat=%0d rdata=%h want lat=%0d rdata=%h",
                     ok ? n : -1, rdata, FC, flash_word(24'h000400));
        end
        req1 = 1'b0;
        step();
`endif
        offscreen = 1'b1;
    endtask

    // Random traffic checked at transaction level: grants follow the round-robin
    // rule, every completion arrives FC cycles after its fetch with that requester's
    // flash word, and aborts equal fetches that never completed.
    task automatic test_random_soak();
        logic [23:0] a;
        bit pr0, pr1, poff, ls, inflight, fwho;
        logic [11:0] pwin;
        int fcyc, fetches, completions, run, ea;
        rst = 1'b1;
        req0 = 1'b0;
        req1 = 1'b0;
        step();
        rst = 1'b0;
        ls = 1'b1; inflight = 1'b0; fwho = 1'b0;
        fcyc = 0; fetches = 0; completions = 0; run = 0;
        for (int c = 0; c < 4000; c++) begin
            if (run == 0) begin
                offscreen = ($urandom_range(0, 3) != 0);
                window_left = 12'($urandom_range(0, 120));
                run = $urandom_range(1, 60);
            end else begin
                run--;
            end
            if (!req0 && $urandom_range(0, 9) == 0) begin fresh_addr(a); addr0 = a; req0 = 1'b1; end
            if (!req1 && $urandom_range(0, 9) == 0) begin fresh_addr(a); addr1 = a; req1 = 1'b1; end
            pr0 = req0; pr1 = req1; poff = offscreen; pwin = window_left;
            step();
            if (fetch) begin
                fwho = gnt1;
                total++;
                if (gnt0 === gnt1 || !(poff && pwin >= 12'(GC)) || inflight ||
                    fetch_addr !== (gnt1 ? addr1 : addr0)) begin
                    bad++;
                    $display("FAIL soak_fetch cyc=%0d got gnt=%b%b addr=%h off=%b win=%0d busy_before=%b",
                             cyc, gnt1, gnt0, fetch_addr, poff, pwin, inflight);
                end
                total++;
                if ((pr0 && pr1) ? (fwho !== ~ls) : (fwho !== pr1)) begin
                    bad++;
                    $display("FAIL soak_arb cyc=%0d got=%b want=%b", cyc, fwho, (pr0 && pr1) ? ~ls : pr1);
                end
                inflight = 1'b1;
                fcyc = cyc;
                fetches++;
            end
            if (done0 || done1) begin
                total++;
                if (!inflight || done0 === done1 || done1 !== fwho || cyc - fcyc != FC ||
                    rdata !== flash_word(fwho ? addr1 : addr0)) begin
                    bad++;
                    $display("FAIL soak_done cyc=%0d got done=%b%b lat=%0d rdata=%h want done for %0d lat=%0d rdata=%h",
                             cyc, done1, done0, cyc - fcyc, rdata, fwho, FC, flash_word(fwho ? addr1 : addr0));
                end
                ls = fwho;
                completions++;
                inflight = 1'b0;
                if (done1) req1 = 1'b0; else req0 = 1'b0;
            end
            if (busy === 1'b0) begin
                inflight = 1'b0;
                ea = fetches - completions;
                if (ea > 255) ea = 255;
                total++;
                if (abort_count !== 8'(ea)) begin
                    bad++;
                    $display("FAIL soak_aborts cyc=%0d got=%0d want=%0d", cyc, abort_count, ea);
                end
            end
        end
        req0 = 1'b0;
        req1 = 1'b0;
        step();
        step();
    endtask

    initial begin
        salt = $urandom;
        test_reset();
        test_single_fetch();
        test_round_robin();
        test_window_guard();
        test_abort();
        test_abort_saturation();
        test_reset_mid();
        test_cache();
        test_random_soak();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog got=timeout want=finish");
        $fatal(1, "watchdog expired");
    end
endmodule

// File: doc/word_fetch_scheduler.md
# word_fetch_scheduler

Shares the slow word-list fetch path of `qspi_top` (`fetch` / `fetch_addr` / `fetch_result`) between two game-logic requesters. Requester 0 is guess validation and requester 1 is target-word selection. The block issues flash fetches only inside off-screen windows long enough to finish them, so font rendering is never disturbed. It arbitrates round-robin, times each fetch with a fixed latency counter and re-issues any fetch cut short by the end of a window.

## Interface
Parameters:
- `FETCH_CYCLES`, default 40: cycles from the `fetch` pulse until `fetch_result` is valid.
- `GUARD_CYCLES`, default 48: minimum `window_left` needed to start a fetch.

Ports:
- `clk`  in  1: system clock.
- `rst`  in  1: synchronous, active-high reset.
- `offscreen`  in  1: high while the qspi path is free for word-list access.
- `window_left`  in  12: cycles remaining in the current off-screen window; only meaningful while `offscreen` is high.
- `req0`, `req1`  in  1: request levels; held high until the matching `done`.
- `addr0`, `addr1`  in  24: flash byte address; stable while the matching `req` is high.
- `gnt0`, `gnt1`  out  1: one-cycle pulse when that request is accepted.
- `done0`, `done1`  out  1: one-cycle pulse; `rdata` is valid in the same cycle.
- `rdata`  out  32: result of the last completed request; held until the next `done`.
- `fetch`  out  1: one-cycle fetch strobe to `qspi_top`.
- `fetch_addr`  out  24: address to `qspi_top`; valid while `fetch` is high.
- `fetch_result`  in  32: word from `qspi_top`.
- `busy`  out  1: high in any state other than IDLE.
- `abort_count`  out  8: saturating count of aborted fetches.

## Operation
- All outputs are registered.
- Reset values: state IDLE, all pulses 0, `rdata` 0, `fetch_addr` 0, `abort_count` 0, `last_served` 1, cache invalid.
- FSM has three states: IDLE, WAIT, DONE.

IDLE
- Start condition: some `req` is high, `offscreen`=1 and `window_left >= GUARD_CYCLES`.
- Selection: if both `req` are high, pick the requester that is not `last_served`; otherwise pick the single active one.
- Actions in the next cycle: `fetch`=1, `fetch_addr`=selected address, matching `gnt`=1.
- Counter is loaded with `FETCH_CYCLES`; state moves to WAIT.

WAIT
- The counter decrements every cycle.
- If `offscreen`=0 in any WAIT cycle, including the `fetch` cycle:
  - Abort: state returns to IDLE with no `done`.
  - `abort_count` increments, saturating at 255.
  - `last_served` is unchanged, so the same requester is retried first.
  - The request is still pending because `req` stays high.
- When the counter expires, `fetch_result` is captured into `rdata`.
- The matching `done` pulses, `last_served` is set to that requester, and state moves to DONE.

DONE
- Lasts exactly one cycle, then returns to IDLE.
- Its purpose is to give the requester one cycle to drop `req`.
- No arbitration decision is made in DONE.
- A `req` still high in the IDLE cycle after DONE is treated as a new request.

Other rules
- Only one outstanding fetch at a time.
- `window_left` is only checked at start; a window that closes mid-fetch is handled by the abort rule.
- Reset mid-operation: everything returns to reset values and nothing is pulsed. A requester still holding `req` is served again from scratch.

## Timing
- Decision in cycle N (sampled at the edge ending N) → `fetch`/`gnt` high in N+1.
- `fetch_result` is sampled at the edge ending N+FETCH_CYCLES.
- `done`/`rdata` are valid in N+FETCH_CYCLES+1, exactly `FETCH_CYCLES` cycles after the `fetch` pulse.
- Minimum spacing between `fetch` pulses: FETCH_CYCLES+2 cycles.
- Abort: `offscreen` low in cycle M during WAIT → IDLE in M+1; a new fetch can start no earlier than M+2.
- `abort_count` updates in M+1.

## Configuration
- Macro: `WORD_FETCH_CACHE_EN`.
- Defined: a one-entry cache holds tag (24-bit address + valid) and data (32 bits).
  - Reset and aborts never write the cache; every completed fetch writes it.
  - Hit: in IDLE, the selected address equals the valid tag. This needs no `offscreen` or window check.
  - On a hit, `gnt` pulses in N+1 with no `fetch` pulse, and `rdata` is loaded from the cache in N+1 together with `done`.
  - State goes straight to DONE and `last_served` updates as for a normal completion.
- Undefined: no cache logic; every request performs a flash fetch.

## Test plan
- `req0`, `addr0`=0x001234, `offscreen`=1, `window_left`=500 → `fetch` with `fetch_addr`=0x001234 one cycle after the decision. `done0` follows 40 cycles after `fetch`, with `rdata` equal to the model word.
- `req0` and `req1` both raised one cycle after reset → `req0` served first, then `req1` after DONE; the next simultaneous pair serves `req0` again.
- `window_left`=47 with `offscreen`=1 → no `fetch`; `window_left`=48 → `fetch` issued.
- Drop `offscreen` 10 cycles into WAIT → no `done`, `abort_count`=1. When `offscreen` returns, the same address is re-fetched and completes.
- Assert `rst` 20 cycles into WAIT with `req1` held → all outputs at reset values. `req1` is re-fetched once the window conditions hold and completes normally.
- Cache hit (`WORD_FETCH_CACHE_EN`): fetch 0x000400, then request it again with `offscreen`=0 → `done` one cycle after the decision, no `fetch` pulse, same `rdata`. Without the macro, the second request waits for `offscreen`=1 and `fetch` pulses.
